tag_search_seq: RTL



---
 rtl/tag_search_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/tag_search_seq.sv
// Scans a DEPTH-entry tag table one entry per two cycles through an external 6-bit comparator; lowest matching index wins.
// Latency: done 2*i+3 cycles after start for a hit on entry i, 2*DEPTH+1 for a miss; start outside IDLE is dropped, writes always accepted.
module tag_search_seq #(
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [5:0]      wr_tag,
  input  logic            wr_valid,
  input  logic            start,
  input  logic [5:0]      key,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic [IDXW-1:0] hit_idx,
  output logic [5:0]      cmp_a,
  output logic [5:0]      cmp_b,
  output logic            cmp_enb,
  input  logic            cmp_eq
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [5:0]       tag_tbl [DEPTH];
  logic [DEPTH-1:0] vld_tbl;
  logic [5:0]       key_r;
  logic [IDXW-1:0]  ptr;
  logic             last;

  assign last = (ptr == IDXW'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = DRIVE;
      DRIVE: begin
        busy      = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = (cmp_eq || last) ? DONE : DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table write port is independent of the scan; a DRIVE read sees pre-edge contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tag_tbl[i] <= '0;
      vld_tbl <= '0;
    end else if (wr_en) begin
      tag_tbl[wr_idx] <= wr_tag;
      vld_tbl[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_r   <= '0;
      ptr     <= '0;
      cmp_a   <= '0;
      cmp_b   <= '0;
      cmp_enb <= 1'b0;
      hit     <= 1'b0;
      hit_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          key_r <= key;
          ptr   <= '0;
        end
        DRIVE: begin
          cmp_a   <= key_r;
          cmp_b   <= tag_tbl[ptr];
          cmp_enb <= vld_tbl[ptr];
        end
        // Enable drops as DONE is entered so the comparator idles between searches.
        CHECK: begin
          if (cmp_eq) begin
            hit     <= 1'b1;
            hit_idx <= ptr;
            cmp_enb <= 1'b0;
          end else if (last) begin
            hit     <= 1'b0;
            hit_idx <= '0;
            cmp_enb <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
